// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// Latency: a word accepted at edge k shows its first bit on out during cycle k+1.
// Backpressure: in_ready drops only while the holding register is full; back-to-back words stream gap-free.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sreg_shift_d;

    // Handshake and status decode, driven from registers only (no in_data to out path).
    always_comb begin
        in_ready  = ~hold_full_q;
        accept    = in_valid & ~hold_full_q;
        last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        out_valid = (state_q == SHIFT);
        word_done = last_bit;
        busy      = (state_q == SHIFT) | hold_full_q;
        if (state_q == SHIFT) begin
            out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end else begin
            out = 1'b0;
        end
    end

    // Next shift-register contents: move one place toward the output end, zero fill.
    always_comb begin
        if (MSB_FIRST) begin
            sreg_shift_d = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shift_d = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    // Control FSM: loads, shifts, and hands the pending word over on the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Holding register is always empty here, so a new word goes straight to sreg.
                    if (accept) begin
                        sreg_q  <= in_data;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        sreg_q <= sreg_shift_d;
                        cnt_q  <= cnt_q + CW'(1);
                        if (accept) begin
                            hold_q      <= in_data;
                            hold_full_q <= 1'b1;
                        end
                    end else if (hold_full_q) begin
                        // Pending word takes over with no idle bit; in_ready is low this cycle.
                        sreg_q      <= hold_q;
                        hold_full_q <= 1'b0;
                        cnt_q       <= '0;
                    end else if (accept) begin
                        // Word arriving exactly on the last bit bypasses the holding register.
                        sreg_q <= in_data;
                        cnt_q  <= '0;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: one MSB-first and one LSB-first instance.
// Inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
// Every comparison goes through check(); the summary line reports the totals.
module tb_serial_bit_feeder;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out;
    logic       out_valid;
    logic       word_done;
    logic       busy;

    logic [7:0] l_data;
    logic       l_valid;
    logic       l_ready;
    logic       l_out;
    logic       l_out_valid;
    logic       l_word_done;
    logic       l_busy;

    int n_vec;
    int n_err;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .word_done (word_done),
        .busy      (busy)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .in_data   (l_data),
        .in_valid  (l_valid),
        .in_ready  (l_ready),
        .out       (l_out),
        .out_valid (l_out_valid),
        .word_done (l_word_done),
        .busy      (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] stream;
        logic [7:0]  w;
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        l_data   = 8'h00;
        l_valid  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t1 out c%0d", i), out, 1'b0);
            check($sformatf("t1 out_valid c%0d", i), out_valid, 1'b0);
            check($sformatf("t1 busy c%0d", i), busy, 1'b0);
            check($sformatf("t1 in_ready c%0d", i), in_ready, 1'b1);
            tick();
        end

        // 2: single word MSB first
        w        = 8'b1100_1110;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        check("t2 in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t2 out b%0d", i), out, w[7-i]);
            check($sformatf("t2 out_valid b%0d", i), out_valid, 1'b1);
            check($sformatf("t2 word_done b%0d", i), word_done, (i == 7));
            tick();
        end
        @(negedge clk);
        check("t2 out_valid end", out_valid, 1'b0);
        check("t2 busy end", busy, 1'b0);
        check("t2 out end", out, 1'b0);

        // 3: back-to-back through the holding register
        stream   = 16'hA53C;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_data  = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("t3 out b%0d", i), out, stream[15-i]);
            check($sformatf("t3 out_valid b%0d", i), out_valid, 1'b1);
            check($sformatf("t3 word_done b%0d", i), word_done, (i == 7 || i == 15));
            check($sformatf("t3 in_ready b%0d", i), in_ready, !(i >= 1 && i <= 7));
            tick();
            in_valid = 1'b0;
        end
        @(negedge clk);
        check("t3 out_valid end", out_valid, 1'b0);
        check("t3 busy end", busy, 1'b0);

        // 4: word offered only on the last bit loads sreg directly
        in_data  = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                in_data  = 8'hFF;
                in_valid = 1'b1;
            end
            @(negedge clk);
            check($sformatf("t4 out b%0d", i), out, (i >= 8));
            check($sformatf("t4 out_valid b%0d", i), out_valid, 1'b1);
            check($sformatf("t4 word_done b%0d", i), word_done, (i == 7 || i == 15));
            check($sformatf("t4 in_ready b%0d", i), in_ready, 1'b1);
            tick();
            in_valid = 1'b0;
        end
        @(negedge clk);
        check("t4 out_valid end", out_valid, 1'b0);

        // 5: reset mid-word with a second word pending
        in_data  = 8'hF0;
        in_valid = 1'b1;
        tick();
        in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t5 out b%0d", i), out, 1'b1);
            if (i == 2) begin
                check("t5 in_ready held", in_ready, 1'b0);
                check("t5 busy held", busy, 1'b1);
            end
            tick();
            in_valid = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5 out after rst", out, 1'b0);
        check("t5 out_valid after rst", out_valid, 1'b0);
        check("t5 busy after rst", busy, 1'b0);
        check("t5 in_ready after rst", in_ready, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            @(negedge clk);
            check($sformatf("t5 quiet c%0d", i), out_valid, 1'b0);
            check($sformatf("t5 quiet busy c%0d", i), busy, 1'b0);
        end

        // 6: LSB-first instance
        w       = 8'b0000_0110;
        l_data  = w;
        l_valid = 1'b1;
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t6 out b%0d", i), l_out, w[i]);
            check($sformatf("t6 out_valid b%0d", i), l_out_valid, 1'b1);
            check($sformatf("t6 word_done b%0d", i), l_word_done, (i == 7));
            tick();
        end
        @(negedge clk);
        check("t6 out_valid end", l_out_valid, 1'b0);
        check("t6 busy end", l_busy, 1'b0);
        check("t6 in_ready end", l_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial front end for the serial sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on `out`, which drives the detector's `in` input.
- Double-buffered: a shift register plus a one-word holding register, so back-to-back words stream with no idle bit between them.

Parameters:
- WIDTH, 8, bits per word; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first and shift left; 0 = emit bit 0 first and shift right.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- out  output  1  serial bit stream to the detector.
- out_valid  output  1  `out` carries a real data bit this cycle.
- word_done  output  1  high during the cycle the last bit of a word is on `out`.
- busy  output  1  shifting or holding a pending word.

Behaviour:
- Internal state:
  - sreg[WIDTH-1:0] shift register.
  - hold[WIDTH-1:0] holding register with a hold_full flag.
  - cnt bit counter, clog2(WIDTH) bits.
  - State register with two states: IDLE and SHIFT.
- Reset (synchronous, dominates every other input):
  - State = IDLE; sreg, hold, hold_full and cnt all = 0.
  - Outputs after reset: out=0, out_valid=0, word_done=0, busy=0, in_ready=1.
  - Reset mid-word discards the word in sreg and any word in hold. No partial bits are emitted afterward.
- Outputs are combinational from registers only, with no in_data to out path:
  - in_ready = ~hold_full.
  - accept = in_valid & in_ready.
  - out = sreg[WIDTH-1] (MSB_FIRST=1) or sreg[0] (MSB_FIRST=0) when state==SHIFT; otherwise 0.
  - out_valid = (state==SHIFT).
  - word_done = (state==SHIFT) & (cnt==WIDTH-1).
  - busy = (state==SHIFT) | hold_full.
- IDLE:
  - hold is always empty in this state.
  - On accept: sreg<=in_data, cnt<=0, state<=SHIFT.
  - Otherwise remain in IDLE.
- SHIFT with cnt < WIDTH-1:
  - sreg shifts one position toward the output end, filling with 0; cnt<=cnt+1.
  - On accept: hold<=in_data, hold_full<=1.
- SHIFT with cnt == WIDTH-1 (last bit on `out`), priority order:
  - hold_full=1: sreg<=hold, hold_full<=0, cnt<=0, stay in SHIFT. in_ready is 0 this cycle, so no accept.
  - Else if accept: sreg<=in_data directly (hold stays empty), cnt<=0, stay in SHIFT.
  - Else: state<=IDLE, cnt<=0.
- Timing:
  - Latency: a word accepted at rising edge k presents its first bit on `out` during cycle k+1.
  - Throughput: one word per WIDTH cycles, with no gap while words are available.
- Handshake:
  - The upstream source holds in_data stable while in_valid=1 and in_ready=0.
  - The block never drops or duplicates an accepted word, except when reset is asserted.

Test Plan:
1. Reset, then idle: hold in_valid=0 for 5 cycles -> out=0, out_valid=0, busy=0, in_ready=1 every cycle.
2. Single word, WIDTH=8, MSB_FIRST=1: in_data=8'b1100_1110 accepted at edge k.
   - out over cycles k+1..k+8 = 1,1,0,0,1,1,1,0.
   - word_done only in cycle k+8.
   - out_valid drops and state returns to IDLE at cycle k+9.
3. Back-to-back: 8'hA5 accepted, then 8'h3C offered with in_valid held high.
   - 8'h3C is accepted into hold on the next edge.
   - in_ready=0 until the edge that ends 8'hA5.
   - out = 10100101 followed immediately by 00111100: 16 contiguous valid bits, word_done in cycles 8 and 16.
4. Accept on last bit: hold empty, and 8'hFF offered only in the last-bit cycle of 8'h00.
   - Direct load into sreg; out = eight 0s then eight 1s with no gap; hold_full stays 0.
5. Reset mid-word: assert reset after 3 bits of 8'hF0 while a second word is in hold.
   - Next cycle: out=0, out_valid=0, busy=0, in_ready=1.
   - Neither word is ever emitted.
6. MSB_FIRST=0, in_data=8'b0000_0110 -> out = 0,1,1,0,0,0,0,0.
